// File: rtl/reg_arb_pkg.sv
// Shared constants and FSM encoding for the shared-register arbiter.
// The lock feature is selected at build time with REG_ARB_LOCK_EN.
package reg_arb_pkg;

    localparam int unsigned DEF_N        = 4;
    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_LOCK_MAX = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SERVE  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Width of a requester index; at least one bit even for tiny N.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests, access
// strobes, packed write data, and the registered grant/read-data returns.
interface reg_share_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic [N-1:0]       req;
    logic [N-1:0]       rd;
    logic [N-1:0]       we;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       lock;
    logic [N-1:0]       gnt;
    logic [WIDTH-1:0]   rdata;
    logic               rvalid;
    logic               busy;

    modport master (
        output req, rd, we, wdata, lock,
        input  gnt, rdata, rvalid, busy
    );

    modport slave (
        input  req, rd, we, wdata, lock,
        output gnt, rdata, rvalid, busy
    );

endinterface

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward
// from ptr+1 (mod N), returned one-hot.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          any
);

    always_comb begin
        int idx;
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 1; k <= int'(N); k++) begin
            idx = int'(ptr) + k;
            if (idx >= int'(N)) begin
                idx = idx - int'(N);
            end
            if (!any && req[PW'(idx)]) begin
                win[PW'(idx)] = 1'b1;
                any           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sequencing N requesters onto one shared WIDTH-bit
// register; REG_ARB_LOCK_EN adds bounded re-grant of a locked winner.
module reg_share_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_share_arbiter_if.slave   bus
);

    localparam int unsigned PW = ptr_w(N);
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] rdata_nxt;
    logic [WIDTH-1:0] wsel;
    logic [N-1:0]     gnt_nxt;
    logic [N-1:0]     pick_win;
    logic [N-1:0]     sel;
    logic [PW-1:0]    sel_idx;
    logic             pick_any;
    logic             sel_any;
    logic             rvalid_nxt;
    logic             relock;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (pick_win),
        .any (pick_any)
    );

`ifdef REG_ARB_LOCK_EN
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Previous winner still holding req+lock keeps the grant until the cap.
    assign relock = (state != ST_IDLE) && bus.req[ptr] && bus.lock[ptr]
                    && (cnt < CW'(LOCK_MAX));

    always_comb begin
        cnt_nxt = '0;
        if (relock) begin
            cnt_nxt = cnt + CW'(1);
        end else if (pick_any) begin
            cnt_nxt = CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    logic          unused_lock;
    logic [CW-1:0] unused_lock_cap;

    assign relock          = 1'b0;
    assign unused_lock_cap = CW'(LOCK_MAX);
    assign unused_lock     = ^{bus.lock, unused_lock_cap};
`endif

    // Final winner selection, its index and its write word.
    always_comb begin
        sel     = relock ? (N'(1) << ptr) : pick_win;
        sel_any = relock | pick_any;
        sel_idx = '0;
        wsel    = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (sel[i]) begin
                sel_idx = PW'(i);
                wsel    = bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and access sequencing; read samples the register before the write.
    always_comb begin
        state_nxt  = ST_IDLE;
        gnt_nxt    = '0;
        ptr_nxt    = ptr;
        rvalid_nxt = 1'b0;
        rdata_nxt  = bus.rdata;
        shreg_nxt  = shreg;
        if (sel_any) begin
            state_nxt = relock ? ST_LOCKED : ST_SERVE;
            gnt_nxt   = sel;
            ptr_nxt   = sel_idx;
            if (bus.rd[sel_idx]) begin
                rdata_nxt  = shreg;
                rvalid_nxt = 1'b1;
            end
            if (bus.we[sel_idx]) begin
                shreg_nxt = wsel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= PW'(N - 1);
            shreg      <= '0;
            bus.gnt    <= '0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            ptr        <= ptr_nxt;
            shreg      <= shreg_nxt;
            bus.gnt    <= gnt_nxt;
            bus.rdata  <= rdata_nxt;
            bus.rvalid <= rvalid_nxt;
        end
    end

    assign bus.busy = (|bus.req) | (|bus.gnt);

endmodule
